// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: PC link, memory read port and the decode handshake.
// The fetch unit takes the master side; the PC/memory/decode environment takes the slave side.
interface fetch_unit_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] pc_addr;
   logic              pc_inc;
   logic              flush;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] ir_opcode;
   logic [DATA_W-1:0] ir_operand;
   logic              instr_valid;
   logic              decode_ready;

   modport master (
      input  pc_addr, flush, mem_ready, mem_data, decode_ready,
      output pc_inc, mem_addr, mem_rd, ir_opcode, ir_operand, instr_valid
   );

   modport slave (
      output pc_addr, flush, mem_ready, mem_data, decode_ready,
      input  pc_inc, mem_addr, mem_rd, ir_opcode, ir_operand, instr_valid
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads an opcode and an optional operand at the PC,
// pulses the PC increment per accepted byte and hands the instruction to decode.
module fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic         clock,
   input  logic         reset,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_ARG = 2'd1,
      VALID     = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              mem_rd;
   logic              accept;
   logic [DATA_W-1:0] ir_opcode;
   logic [DATA_W-1:0] ir_operand;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values that were present before the clock edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FETCH_OP;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a signal unassigned (no latch).
   always_comb begin
      next_state = state;
      mem_rd     = 1'b0;
      if (reset) begin
         next_state = FETCH_OP;
      end else if (bus.flush) begin
         next_state = FETCH_OP;
      end else begin
         case (state)
            FETCH_OP: begin
               mem_rd = 1'b1;
               if (bus.mem_ready) begin
                  next_state = bus.mem_data[DATA_W-1] ? FETCH_ARG : VALID;
               end
            end
            FETCH_ARG: begin
               mem_rd = 1'b1;
               if (bus.mem_ready) begin
                  next_state = VALID;
               end
            end
            VALID: begin
               if (bus.decode_ready) begin
                  next_state = FETCH_OP;
               end
            end
            default: next_state = FETCH_OP;
         endcase
      end
   end

   // A byte is taken only when a read is actually requested, so flush and
   // reset already suppress acceptance through mem_rd.
   assign accept = mem_rd && bus.mem_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         ir_opcode  <= '0;
         ir_operand <= '0;
      end else if (accept) begin
         if (state == FETCH_OP) begin
            ir_opcode <= bus.mem_data;
            if (!bus.mem_data[DATA_W-1]) begin
               ir_operand <= '0;
            end
         end else begin
            ir_operand <= bus.mem_data;
         end
      end
   end

   assign bus.mem_addr    = bus.pc_addr;
   assign bus.mem_rd      = mem_rd;
   assign bus.pc_inc      = accept;
   assign bus.ir_opcode   = ir_opcode;
   assign bus.ir_operand  = ir_operand;
   assign bus.instr_valid = (state == VALID);

endmodule
